// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter letting NUM_REQ requesters share one
// uart_transmitter. One frame per grant; the owner's frame is latched on the
// grant edge and the transmitter's busy handshake is tracked with a timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_sending,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int             GW       = $clog2(NUM_REQ);
    localparam logic [GW:0]    NREQ     = (GW+1)'(NUM_REQ);
    localparam logic [7:0]     TO_LIMIT = 8'(BUSY_TIMEOUT);
    localparam logic [GW-1:0]  LG_RESET = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] win_idx;
    logic          win_found;
    logic [GW:0]   cand;
    logic [7:0]    to_cnt;
    logic          grant_load;
    logic          to_fire;

    // Round-robin search: start just after the last winner and wrap around.
    // The sum last_grant+i stays below 2*NUM_REQ, so one subtraction wraps it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (GW+1)'(i);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && req_valid[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    // State register; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic plus the grant-load and timeout strobes.
    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        to_fire    = 1'b0;
        case (state)
            IDLE: begin
                // A busy transmitter (e.g. a frame left over from before a
                // reset) blocks new grants entirely.
                if (!tx_busy && win_found) begin
                    grant_load = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt + 8'd1 == TO_LIMIT) begin
                    // Give up on this frame; it is not retried.
                    to_fire   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, latched frame, busy timeout counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data     <= '0;
            grant_id    <= '0;
            last_grant  <= LG_RESET;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_load) begin
                tx_data    <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                grant_id   <= win_idx;
                last_grant <= win_idx;
            end
            if (state == WAIT_BUSY && !tx_busy && !to_fire) to_cnt <= to_cnt + 8'd1;
            else                                            to_cnt <= '0;
            if (to_fire) timeout_err <= 1'b1;
        end
    end

    // ISSUE is the only state that pulses the transmitter and the owner.
    assign tx_sending = (state == ISSUE);
    assign req_ready  = tx_sending ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign active     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven round-robin vectors plus hand sequences for
// busy hold-off, busy timeout and mid-frame reset. Expected grants go into a
// scoreboard queue and are popped whenever the arbiter pulses tx_sending.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [31:0] req_data;
    logic [3:0] req_ready;
    logic       tx_sending;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [1:0] grant_id;
    logic       active;
    logic       timeout_err;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_sending(tx_sending), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          n;
        int          ord[4];
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[7];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_send = 0;
    int   busy_mode;   // 0: transmitter model, 1: busy forced high, 2: busy never rises
    int   bcnt;
    bit   hold_all;    // requesters keep valid after ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input int n,
                                input int o0, input int o1, input int o2, input int o3);
        vec_t r;
        r.valid = v; r.data = d; r.n = n;
        r.ord[0] = o0; r.ord[1] = o1; r.ord[2] = o2; r.ord[3] = o3;
        return r;
    endfunction

    function automatic exp_t mk_exp(input int id, input logic [31:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d[id*8 +: 8];
        return e;
    endfunction

    // Transmitter and requester models, driven 1 ns after the active edge.
    always @(posedge clk) begin
        logic       sent;
        logic [3:0] rdy;
        sent = tx_sending;
        rdy  = req_ready;
        #1;
        if (!hold_all) req_valid = req_valid & ~rdy;
        case (busy_mode)
            1: begin tx_busy = 1'b1; bcnt = 0; end
            2: begin tx_busy = 1'b0; bcnt = 0; end
            default: begin
                if (sent === 1'b1) begin
                    bcnt = 10; tx_busy = 1'b1;
                end else if (bcnt > 0) begin
                    bcnt--; tx_busy = (bcnt > 0);
                end else begin
                    tx_busy = 1'b0;
                end
            end
        endcase
    end

    // Scoreboard: every sending pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (tx_sending === 1'b1) begin
            n_send++;
            if (sbq.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_send: got grant %0d data %0h, none expected", grant_id, tx_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("grant_id", grant_id, e.id);
                check("tx_data", tx_data, e.data);
                check("req_ready", req_ready, 32'(4'b0001 << e.id));
            end
        end else if (reset === 1'b0) begin
            check("ready_idle", req_ready, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (!(req_valid == 4'b0 && !active && !tx_busy && sbq.size() == 0) && c < 300) begin
            @(negedge clk); c++;
        end
        check(name, (c < 300), 1);
    endtask

    task automatic wait_send(input string name);
        int c = 0;
        while (tx_sending !== 1'b1 && c < 50) begin
            @(negedge clk); c++;
        end
        check(name, tx_sending, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_active"}, active, 0);
        check({tag, "_sending"}, tx_sending, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
        busy_mode = 0; bcnt = 0; hold_all = 1'b0;

        // Orders assume last_grant=3 after reset and carry over vector to vector.
        vecs[0] = mk(4'b0100, 32'h44A52211, 1, 2, 0, 0, 0);
        vecs[1] = mk(4'b1111, 32'h3C2B1A09, 4, 3, 0, 1, 2);
        vecs[2] = mk(4'b0001, 32'h000000E7, 1, 0, 0, 0, 0);
        vecs[3] = mk(4'b1001, 32'h9F00006E, 2, 3, 0, 0, 0);
        vecs[4] = mk(4'b1010, 32'h5500AA00, 2, 1, 3, 0, 0);
        vecs[5] = mk(4'b0110, 32'h00C3D200, 2, 1, 2, 0, 0);
        vecs[6] = mk(4'b1100, 32'h8E7F0000, 2, 3, 2, 0, 0);

        tick(3);
        check_reset_vals("por");
        reset = 1'b0;
        tick(1);

        for (int k = 0; k < 7; k++) begin
            req_data = vecs[k].data;
            for (int j = 0; j < vecs[k].n; j++) sbq.push_back(mk_exp(vecs[k].ord[j], vecs[k].data));
            req_valid = vecs[k].valid;
            wait_idle($sformatf("vec%0d_done", k));
        end

        // Fairness: everyone stays valid for eight frames.
        do_reset();
        hold_all = 1'b1;
        req_data = 32'hD4C3B2A1;
        for (int j = 0; j < 8; j++) sbq.push_back(mk_exp(j % 4, req_data));
        base = n_send;
        req_valid = 4'b1111;
        begin
            int c = 0;
            while (n_send < base + 8 && c < 400) begin @(negedge clk); c++; end
            check("fair_frames", n_send - base, 8);
        end
        req_valid = 4'b0;
        hold_all = 1'b0;
        wait_idle("fair_done");

        // Busy hold-off: nothing issues while the transmitter is busy.
        do_reset();
        busy_mode = 1;
        tick(2);
        req_data = 32'h000000C1;
        req_valid = 4'b0001;
        base = n_send;
        tick(20);
        check("holdoff_nosend", n_send, base);
        check("holdoff_idle", active, 0);
        sbq.push_back(mk_exp(0, req_data));
        busy_mode = 0;
        begin
            int c = 0;
            while (tx_sending !== 1'b1 && c < 3) begin @(negedge clk); c++; end
            check("holdoff_release", tx_sending, 1);
        end
        wait_idle("holdoff_done");

        // Busy timeout: transmitter never answers.
        busy_mode = 2;
        req_data = 32'h00005A00;
        sbq.push_back(mk_exp(1, req_data));
        req_valid = 4'b0010;
        wait_send("to_send");
        tick(15);
        check("to_err_early", timeout_err, 0);
        check("to_active_early", active, 1);
        tick(1);
        check("to_err_set", timeout_err, 1);
        check("to_back_idle", active, 0);
        req_data = 32'h00D40000;
        sbq.push_back(mk_exp(2, req_data));
        req_valid = 4'b0100;
        wait_idle("to_next_served");
        check("to_err_sticky", timeout_err, 1);

        // Reset while the transmitter is mid-frame.
        busy_mode = 0;
        req_data = 32'h77665544;
        sbq.push_back(mk_exp(2, req_data));
        req_valid = 4'b0100;
        wait_send("rst_send");
        busy_mode = 1;
        tick(4);
        check("rst_in_frame", active, 1);
        req_valid = 4'b1001;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset_vals("midrst");
        base = n_send;
        tick(5);
        check("midrst_nosend", n_send, base);
        sbq.push_back(mk_exp(0, req_data));
        sbq.push_back(mk_exp(3, req_data));
        busy_mode = 0;
        wait_idle("midrst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_transmitter, 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: frame payload width; equals the transmitter's FRAME_DATA_LENGTH.
REQ-003 Parameter BUSY_TIMEOUT, default 15: cycles allowed from the sending pulse to the transmitter's busy rising, 1..255.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  bit i high: requester i holds a frame.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  frame of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot single-cycle pulse: frame i accepted.
REQ-009 tx_sending  output  1  to transmitter sending input.
REQ-010 tx_data  output  DATA_WIDTH  to transmitter data input.
REQ-011 tx_busy  input  1  from transmitter busy output.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-013 active  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  sticky flag: transmitter failed to go busy in time.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, all registered.
REQ-016 IDLE: if tx_busy==0 and any req_valid bit set -> select winner, latch its req_data into tx_data, load grant_id, go ISSUE; otherwise stay.
REQ-017 IDLE with tx_busy==1 issues nothing regardless of req_valid.
REQ-018 Round-robin: search starts at index (last_grant+1) mod NUM_REQ and wraps; first set req_valid bit wins.
REQ-019 last_grant updates on every IDLE->ISSUE transition; reset value NUM_REQ-1, so requester 0 has top priority after reset.
REQ-020 ISSUE lasts exactly one cycle: tx_sending=1, req_ready[grant_id]=1, all other req_ready bits 0; then go WAIT_BUSY.
REQ-021 tx_sending and req_ready are 0 in every state other than ISSUE.
REQ-022 Latency: req_valid sampled high in IDLE at edge n -> tx_sending and req_ready high during cycle n+1.
REQ-023 WAIT_BUSY: tx_busy==1 -> go WAIT_DONE, clear timeout counter; else increment 8-bit counter; counter reaching BUSY_TIMEOUT -> set timeout_err, go IDLE, no retry.
REQ-024 WAIT_DONE: stay while tx_busy==1; tx_busy==0 -> go IDLE.
REQ-025 tx_data and grant_id hold from the ISSUE-entry edge until the next IDLE->ISSUE edge.
REQ-026 Requester i keeps req_valid and its data stable until it sees req_ready[i]; deasserting req_valid after the grant edge does not abort the frame.
REQ-027 Back-to-back: minimum gap between two tx_sending pulses is ISSUE + 1 WAIT_BUSY cycle + frame duration + 1 IDLE cycle.
REQ-028 A requester that keeps req_valid high continuously gets at most one frame per NUM_REQ grants while other requesters are valid.
REQ-029 active = (state != IDLE).
REQ-030 timeout_err stays set until reset; the arbiter continues serving requests while it is set.

Reset
REQ-031 On reset==1 at a posedge: state=IDLE, tx_sending=0, req_ready=0, tx_data=0, grant_id=0, last_grant=NUM_REQ-1, timeout counter=0, timeout_err=0.
REQ-032 Reset mid-frame does not reset the transmitter; after reset the arbiter waits in IDLE until tx_busy==0 before issuing.
REQ-033 reset has priority over every FSM transition in the same cycle.

Verification
REQ-034 Single request: req_valid=4'b0100, data 8'hA5, tx_busy model rises 1 cycle after sending and stays 10 cycles -> one tx_sending pulse with tx_data=8'hA5, req_ready=4'b0100 in the same cycle, grant_id=2.
REQ-035 Fairness: all four req_valid held high for 8 frames -> grant order 0,1,2,3,0,1,2,3, with exactly one ready pulse per frame.
REQ-036 Busy hold-off: tx_busy forced 1 while req_valid=4'b0001 -> no tx_sending until tx_busy falls, then sending is high within 2 cycles.
REQ-037 Timeout: tx_busy held 0 after sending, BUSY_TIMEOUT=15 -> timeout_err set 15 cycles after WAIT_BUSY entry, FSM back in IDLE, next request still served.
REQ-038 Reset during WAIT_DONE with tx_busy=1 -> all outputs at reset values next cycle; no tx_sending until tx_busy==0; requester 0 wins the first grant.
REQ-039 Simultaneous: req_valid 4'b1001 arriving with last_grant=0 -> requester 3 granted first, then requester 0.
